ooo_mem_model: RTL

//  Synthesizable out-of-order memory responder; sits directly downstream of the ROB.

---
 rtl/ooo_mem_model.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ooo_mem_model.sv
// rtl/ooo_mem_model.sv - out-of-order memory responder, one slot per ROB tag
// Build option: MEM_RSP_RANDOM_EN selects LFSR-driven latency and arbitration start.
module ooo_mem_model #(
    parameter int          ROB_SIZE    = 16,
    parameter int          SWIDTH      = 4,
    parameter int          AWIDTH      = 40,
    parameter int          DWIDTH      = 32,
    parameter int          LAT_MIN     = 2,
    parameter int          LAT_MAX_PTR = 3,
    parameter logic [31:0] LFSR_SEED   = 32'h1d76993a
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              mem_req_val,
    input  logic [AWIDTH-1:0] mem_req_addr,
    input  logic [SWIDTH-1:0] mem_req_ID,
    output logic              mem_rsp_val,
    output logic [SWIDTH-1:0] mem_rsp_ID,
    output logic [DWIDTH-1:0] mem_rsp_data,
    output logic [SWIDTH:0]   outstanding,
    output logic              err_dup_id
);
    localparam int CW = (AWIDTH < DWIDTH) ? AWIDTH : DWIDTH;

    logic [ROB_SIZE-1:0] vld;
    logic [ROB_SIZE-1:0] elig;
    logic [8:0]          timer     [ROB_SIZE];
    logic [DWIDTH-1:0]   slot_data [ROB_SIZE];
    logic [DWIDTH-1:0]   req_data;
    logic [8:0]          lat;
    logic [SWIDTH-1:0]   start;
    logic [SWIDTH-1:0]   idx;
    logic [SWIDTH-1:0]   gnt_id;
    logic                gnt_val;
    logic                same_tag;
    logic                acc_inc;
    logic                unused_bits;

`ifdef MEM_RSP_RANDOM_EN
    logic [31:0] lfsr;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 32'h80200003) : (lfsr >> 1);
    end

    assign lat         = 9'(LAT_MIN) + 9'(lfsr[7:0] & 8'((1 << LAT_MAX_PTR) - 1));
    assign start       = lfsr[SWIDTH+7:8];
    assign unused_bits = ^{mem_req_addr, lfsr};
`else
    localparam int          unused_lat_ptr = LAT_MAX_PTR;
    localparam logic [31:0] unused_seed    = LFSR_SEED;

    // Rotating priority: the tag after the last one granted goes first.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_)
            start <= '0;
        else if (gnt_val)
            start <= gnt_id + SWIDTH'(1);
    end

    assign lat         = 9'(LAT_MIN);
    assign unused_bits = ^mem_req_addr;
`endif

    always_comb begin
        req_data         = '0;
        req_data[CW-1:0] = mem_req_addr[CW-1:0];
    end

    always_comb begin
        elig    = '0;
        gnt_val = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int i = 0; i < ROB_SIZE; i++)
            elig[i] = vld[i] && (timer[i] == 9'd0);
        for (int k = 0; k < ROB_SIZE; k++) begin
            idx = start + SWIDTH'(k);
            if (!gnt_val && elig[idx]) begin
                gnt_val = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    // A request landing on the tag being granted reuses the slot, not a duplicate.
    assign same_tag = gnt_val && (gnt_id == mem_req_ID);
    assign acc_inc  = mem_req_val && (!vld[mem_req_ID] || same_tag);

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            vld          <= '0;
            mem_rsp_val  <= 1'b0;
            mem_rsp_ID   <= '0;
            mem_rsp_data <= '0;
            outstanding  <= '0;
            err_dup_id   <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                timer[i]     <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROB_SIZE; i++)
                if (vld[i] && timer[i] != 9'd0)
                    timer[i] <= timer[i] - 9'd1;
            if (gnt_val) begin
                vld[gnt_id]  <= 1'b0;
                mem_rsp_val  <= 1'b1;
                mem_rsp_ID   <= gnt_id;
                mem_rsp_data <= slot_data[gnt_id];
            end else begin
                mem_rsp_val  <= 1'b0;
            end
            if (mem_req_val) begin
                vld[mem_req_ID]       <= 1'b1;
                timer[mem_req_ID]     <= lat;
                slot_data[mem_req_ID] <= req_data;
                if (vld[mem_req_ID] && !same_tag)
                    err_dup_id <= 1'b1;
            end
            outstanding <= outstanding + (SWIDTH+1)'(acc_inc) - (SWIDTH+1)'(gnt_val);
        end
    end
endmodule
